// File: rtl/spike_scanner_if.sv
// Purpose : bundles the spike_scanner phase/frame/shift inputs and pair/status outputs.
// Ports   : master = controller/sequencer side, slave = spike_scanner side.
// Latency : none (wires only); no backpressure of its own.
interface spike_scanner_if #(
  parameter int N_NUM = 32,
  parameter int N_SZ  = 5
);
  logic [2:0]       state;
  logic [N_NUM-1:0] spike_in;
  logic             spike_load;
  logic             shift_en;
  logic [N_SZ-1:0]  rf_addr;
  logic [1:0]       spike;
  logic             scan_done;
  logic [N_SZ:0]    spike_cnt;

  modport master (
    output state, spike_in, spike_load, shift_en,
    input  rf_addr, spike, scan_done, spike_cnt
  );

  modport slave (
    input  state, spike_in, spike_load, shift_en,
    output rf_addr, spike, scan_done, spike_cnt
  );
endinterface

// File: rtl/spike_scanner.sv
// Purpose : holds one spike frame and presents it an even/odd neuron pair per cycle during SYN_ACCU.
// Ports   : i_clk, i_rst (sync, active-low), bus (slave): state/spike_in/spike_load/shift_en in,
//           rf_addr/spike/scan_done/spike_cnt out. Latency: SCAN entered one edge after SYN_ACCU.
// Backpr. : advances one pair per edge with shift_en high; shift_en never reaches an output.
module spike_scanner #(
  parameter int N_NUM = 32,
  parameter int N_SZ  = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  spike_scanner_if.slave bus
);
  localparam logic [2:0]      SYN_ACCU = 3'b010;
  localparam logic [N_SZ-1:0] LAST_PAIR = N_SZ'(N_NUM - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SCAN = 2'b01,
    S_FIN  = 2'b10
  } fsm_t;

  fsm_t             r_fsm;
  fsm_t             w_fsm_nxt;
  logic [N_NUM-1:0] r_buf;
  logic [N_SZ-1:0]  r_rf_addr;
  logic [N_SZ:0]    r_spike_cnt;

  logic             w_in_syn;
  logic             w_load;
  logic             w_shift;
  logic [1:0]       w_spike;
  logic [N_SZ:0]    w_pop;
  logic [N_SZ:0]    w_cnt_dec;

  assign w_in_syn = (bus.state == SYN_ACCU);
  // A new frame may only replace the buffer while no scan is consuming it.
  assign w_load   = bus.spike_load && (r_fsm != S_SCAN);
  // Abort (leaving SYN_ACCU) wins over a simultaneous shift.
  assign w_shift  = (r_fsm == S_SCAN) && w_in_syn && bus.shift_en;

  assign w_spike   = (r_fsm == S_SCAN) ? r_buf[r_rf_addr +: 2] : 2'b00;
  assign w_pop     = (N_SZ+1)'(w_spike[0]) + (N_SZ+1)'(w_spike[1]);
  assign w_cnt_dec = (r_spike_cnt > w_pop) ? (r_spike_cnt - w_pop) : '0;

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE: if (w_in_syn) w_fsm_nxt = S_SCAN;
      S_SCAN: begin
        if (!w_in_syn) begin
          w_fsm_nxt = S_IDLE;
        end else if (bus.shift_en && (r_rf_addr == LAST_PAIR)) begin
          w_fsm_nxt = S_FIN;
        end
      end
      S_FIN:  if (!w_in_syn) w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_buf       <= '0;
      r_rf_addr   <= '0;
      r_spike_cnt <= '0;
    end else begin
      if (w_load) begin
        r_buf       <= bus.spike_in;
        r_spike_cnt <= (N_SZ+1)'($countones(bus.spike_in));
      end
      if ((r_fsm == S_SCAN) && !w_in_syn) begin
        r_rf_addr <= '0;
      end else if (w_shift) begin
        r_spike_cnt <= w_cnt_dec;
        r_rf_addr   <= (r_rf_addr == LAST_PAIR) ? '0 : r_rf_addr + N_SZ'(2);
      end
    end
  end

  assign bus.rf_addr   = r_rf_addr;
  assign bus.spike     = w_spike;
  assign bus.scan_done = (r_fsm == S_FIN);
  assign bus.spike_cnt = r_spike_cnt;
endmodule

// File: doc/spike_scanner.md
# spike_scanner

Upstream feeder for the population controller. Holds one timestep's input spike frame and presents it two neurons at a time (even/odd pair) as `rf_addr` / `spike[1:0]` during `SYN_ACCU`. Advances one pair per cycle in which the controller's `shift_en` is sampled high, and reports scan completion and the remaining spike count to the top-level sequencer.

## Interface
- `N_NUM`, 32, number of input neurons per frame; must be even.
- `N_SZ`, 5, width of the neuron index; equals log2(`N_NUM`).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `state`  in  3  global phase code: IDLE=000, SET=001, SYN_ACCU=010, DECAY=011, PDE=100, FINISH=101, DONE=110.
- `spike_in`  in  `N_NUM`  spike frame to load.
- `spike_load`  in  1  load strobe for `spike_in`.
- `shift_en`  in  1  advance request from the controller.
- `rf_addr`  out  `N_SZ`  even index of the current pair.
- `spike`  out  2  {`buf[rf_addr+1]`, `buf[rf_addr]`}; 00 outside SCAN.
- `scan_done`  out  1  high while the FSM is in FIN.
- `spike_cnt`  out  `N_SZ`+1  spikes not yet shifted out.

## Operation
- Registers: `buf[N_NUM-1:0]`, `rf_addr`, `spike_cnt`, and a 2-bit FSM with states IDLE=00, SCAN=01, FIN=10.
- Load:
  - When `spike_load`=1 and the FSM is in IDLE or FIN: `buf` <= `spike_in` and `spike_cnt` <= popcount(`spike_in`).
  - When the FSM is in SCAN, `spike_load` is ignored entirely.
- IDLE:
  - `rf_addr`=0, `spike`=00.
  - If `state`==SYN_ACCU, go to SCAN next cycle.
  - A load in the same cycle is used by the scan.
- SCAN:
  - `spike` is a combinational slice of `buf` at the registered `rf_addr`.
  - On an edge with `shift_en`=1:
    - `spike_cnt` <= `spike_cnt` − popcount(`spike`), floored at 0.
    - If `rf_addr`==`N_NUM`−2: go to FIN and set `rf_addr` <= 0.
    - Otherwise `rf_addr` <= `rf_addr`+2.
  - With `shift_en`=0, everything holds.
- FIN:
  - `spike`=00, `scan_done`=1.
  - Leave to IDLE when `state`!=SYN_ACCU.
- Abort:
  - `state`!=SYN_ACCU while in SCAN: go to IDLE next cycle and set `rf_addr` <= 0.
  - `buf` and `spike_cnt` are retained and are not decremented on the abort edge.
- The odd bit of `rf_addr` is never set; `rf_addr` never exceeds `N_NUM`−2, so there is no wrap-around.
- All outputs are registered or derived combinationally from registers and `state`. There is no path from `shift_en` to any output, so the combinational `shift_en` loop through the controller is broken.

## Timing
- Reset (`rst`=0 at an edge):
  - FSM=IDLE, `buf`=0, `rf_addr`=0, `spike_cnt`=0.
  - Therefore `spike`=00 and `scan_done`=0.
  - Reset overrides load and shift in the same cycle, and takes effect mid-scan.
- Entry latency: `state` becomes SYN_ACCU at edge t; the FSM is in SCAN from edge t+1, with pair 0 presented.
- Each pair is visible for at least 1 cycle. The controller raises `shift_en` in the same cycle for zero pairs, so an all-zero frame scans in `N_NUM`/2 = 16 cycles.
- `scan_done` rises on the edge that consumes pair `N_NUM`/2−1, and falls one edge after `state` leaves SYN_ACCU.
- `spike_cnt` updates on the same edge as `rf_addr`.

## Test plan
- **Reset:** `rst`=0 for 2 cycles with random inputs -> `rf_addr`=0, `spike`=00, `scan_done`=0, `spike_cnt`=0; then load 32'hFFFF_FFFF -> `spike_cnt`=32.
- **Zero frame:** load 32'h0, `state`=SYN_ACCU, `shift_en` tied 1 -> `rf_addr` steps 0,2,…,30 over 16 cycles, `spike`=00 throughout, `scan_done`=1 on cycle 17, `spike_cnt` stays 0.
- **Edge pairs:** load 32'h8000_0001 -> pair 0 `spike`=01 and pair 30 `spike`=10; `spike_cnt` goes 2 -> 1 (after pair 0) -> 0 (after pair 30).
- **Stall:** load 32'h0000_0030 and hold `shift_en`=0 for 3 cycles at `rf_addr`=4 -> `rf_addr`=4, `spike`=11, `spike_cnt`=2 stable; first `shift_en` edge -> `rf_addr`=6, `spike_cnt`=0.
- **Abort:** `state` goes to DECAY while `rf_addr`=10 -> next cycle FSM=IDLE, `rf_addr`=0, `spike`=00, `scan_done`=0; `spike_cnt` unchanged. Re-entering SYN_ACCU restarts at pair 0 with the same `buf`.
- **Load during SCAN:** pulse `spike_load` with 32'hFFFF_FFFF at `rf_addr`=8 of a 32'h0 frame -> ignored, `spike` stays 00 to the end. The same load in FIN is accepted (`spike_cnt`=32).
